// File: rtl/puzzle_pkg.sv
// puzzle_pkg
// Shared constants, move codes, FSM state type and small helpers for the
// 2x3 sliding-puzzle solution player.
//
// Board packing: cell i occupies bits [3i+2:3i], value BLANK marks the blank.
// Solution word: [44:40] move count, [39:38] first move ... [1:0] 20th move.
package puzzle_pkg;

   // Move codes act on the blank cell.
   localparam logic [1:0] MOVE_UP    = 2'b11;  // idx - 3
   localparam logic [1:0] MOVE_DOWN  = 2'b00;  // idx + 3
   localparam logic [1:0] MOVE_LEFT  = 2'b10;  // idx - 1
   localparam logic [1:0] MOVE_RIGHT = 2'b01;  // idx + 1

   localparam int N_CELLS = 6;
   localparam int COLS    = 3;
   localparam int CELL_W  = 3;
   localparam int BOARD_W = N_CELLS * CELL_W;

   localparam logic [CELL_W-1:0] BLANK = 3'd5;

   localparam int MAX_MOVES = 20;
   localparam int SOL_W     = 45;
   localparam int CNT_W     = 5;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

   // Cells 0..5 hold values 0..5 (octal digits, most significant = cell 5).
   localparam logic [BOARD_W-1:0] GOAL_BOARD = 18'o543210;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIN  = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   // Column of a cell index in the row-major 2x3 grid.
   function automatic logic [1:0] col_of(input logic [2:0] idx);
      logic [2:0] c;
      c = (idx >= 3'd3) ? (idx - 3'd3) : idx;
      return c[1:0];
   endfunction

endpackage

// File: rtl/puzzle_step_timer.sv
// puzzle_step_timer
// Step interval counter: counts 0..TICK_DIV-1 while enabled and raises tick
// in the cycle it sits at TICK_DIV-1, then wraps to 0.
//
// Parameters: TICK_DIV  cycles per tick (>= 2)
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   clr   in   synchronous clear of the counter (wins over en)
//   en    in   count enable
//   tick  out  high for one cycle at the end of each interval
module puzzle_step_timer #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/puzzle_solution_player.sv
// puzzle_solution_player
// Latches one solution word and a starting board, then replays the encoded
// blank moves one per TICK_DIV cycles on an internal board register.
//
// Build option: define PUZZLE_GOAL_CHECK_EN to compare the final board with
// GOAL_BOARD on completion; otherwise solved is tied low.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle replay request, honoured only in IDLE
//   sol_word   in   [44:40] count, [39:38] first move ... [1:0] 20th move
//   board_in   in   starting board, cell i at [3i+2:3i], 5 = blank
//   board_out  out  current board, same packing
//   blank_pos  out  current blank index 0..5
//   step_idx   out  moves applied so far
//   busy       out  high from the end of LOAD through the last move
//   done       out  one-cycle pulse on successful completion
//   err        out  sticky failure flag, cleared by an accepted start
//   solved     out  final board matched the goal (option above)
//   state_dbg  out  current FSM state
//
// Handshake: start is a single-cycle request with no ready; it is accepted
// only when state_dbg is ST_IDLE and silently dropped otherwise.
module puzzle_solution_player
   import puzzle_pkg::*;
#(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SOL_W-1:0]    sol_word,
   input  logic [BOARD_W-1:0]  board_in,
   output logic [BOARD_W-1:0]  board_out,
   output logic [2:0]          blank_pos,
   output logic [CNT_W-1:0]    step_idx,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                solved,
   output state_t              state_dbg
);

   state_t state, state_nx;

   logic [SOL_W-1:0]   sol_lat;
   logic [BOARD_W-1:0] brd_lat;
   logic [CNT_W-1:0]   cnt_lat;

   logic [2:0]         blank_cnt;
   logic [2:0]         first_blank;
   logic               load_ok;

   logic [1:0]         mv;
   logic [1:0]         col;
   logic               legal;
   logic [2:0]         target;
   logic [BOARD_W-1:0] moved;
   logic               last_move;

   logic               tick;

   logic               do_start, do_load, load_fail, do_move, move_fail, do_fin;

   assign cnt_lat   = sol_lat[SOL_W-1 -: CNT_W];
   assign state_dbg = state;

   puzzle_step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (do_start),
      .en   (state == ST_RUN),
      .tick (tick)
   );

   // Blank census of the latched board; scanning downward leaves the lowest
   // matching index in first_blank.
   always_comb begin
      blank_cnt   = '0;
      first_blank = '0;
      for (int i = N_CELLS - 1; i >= 0; i--) begin
         if (brd_lat[i*CELL_W +: CELL_W] == BLANK) begin
            blank_cnt   = blank_cnt + 3'd1;
            first_blank = 3'(i);
         end
      end
   end

   assign load_ok = (blank_cnt == 3'd1) && (cnt_lat <= MAX_CNT);

   // Current move field; only indices below the count are ever reached.
   always_comb begin
      mv = MOVE_DOWN;
      for (int i = 0; i < MAX_MOVES; i++) begin
         if (step_idx == CNT_W'(i)) mv = sol_lat[(SOL_W - 6) - 2*i -: 2];
      end
   end

   // Legality and target cell of the current move; target stays on the
   // blank when illegal so the swap read below never leaves the board.
   always_comb begin
      col    = col_of(blank_pos);
      legal  = 1'b0;
      target = blank_pos;
      case (mv)
         MOVE_UP:    if (blank_pos >= 3'd3) begin legal = 1'b1; target = blank_pos - 3'd3; end
         MOVE_DOWN:  if (blank_pos <= 3'd2) begin legal = 1'b1; target = blank_pos + 3'd3; end
         MOVE_LEFT:  if (col != 2'd0)       begin legal = 1'b1; target = blank_pos - 3'd1; end
         MOVE_RIGHT: if (col != 2'd2)       begin legal = 1'b1; target = blank_pos + 3'd1; end
         default:    ;
      endcase
   end

   always_comb begin
      moved = board_out;
      moved[CELL_W*target    +: CELL_W] = BLANK;
      moved[CELL_W*blank_pos +: CELL_W] = board_out[CELL_W*target +: CELL_W];
   end

   assign last_move = ((step_idx + 1'b1) == cnt_lat);

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start) state_nx = ST_LOAD;
         ST_LOAD: begin
            if (!load_ok)              state_nx = ST_ERR;
            else if (cnt_lat == '0)    state_nx = ST_FIN;
            else                       state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (tick) begin
               if (!legal)             state_nx = ST_ERR;
               else if (last_move)     state_nx = ST_FIN;
            end
         end
         ST_FIN:  state_nx = ST_IDLE;
         ST_ERR:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // FSM: output strobes driving the datapath
   always_comb begin
      do_start  = (state == ST_IDLE) && start;
      do_load   = (state == ST_LOAD) && load_ok;
      load_fail = (state == ST_LOAD) && !load_ok;
      do_move   = (state == ST_RUN) && tick && legal;
      move_fail = (state == ST_RUN) && tick && !legal;
      do_fin    = (state == ST_FIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sol_lat   <= '0;
         brd_lat   <= '0;
         board_out <= '0;
         blank_pos <= '0;
         step_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (do_start) begin
            sol_lat  <= sol_word;
            brd_lat  <= board_in;
            step_idx <= '0;
            err      <= 1'b0;
         end
         if (do_load) begin
            board_out <= brd_lat;
            blank_pos <= first_blank;
            busy      <= 1'b1;
         end
         if (do_move) begin
            board_out <= moved;
            blank_pos <= target;
            step_idx  <= step_idx + 1'b1;
         end
         if (load_fail || move_fail) begin
            err  <= 1'b1;
            busy <= 1'b0;
         end
         if (do_fin) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

`ifdef PUZZLE_GOAL_CHECK_EN
   logic solved_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           solved_q <= 1'b0;
      else if (do_start) solved_q <= 1'b0;
      else if (do_fin)   solved_q <= (board_out == GOAL_BOARD);
   end

   assign solved = solved_q;
`else
   assign solved = 1'b0;
`endif

endmodule
